// File: rtl/audio_level_meter.sv
// audio_level_meter: XADC samples -> DC-free envelope, 0-15 bar and beat pulse; 3-cycle pipeline.
// Define AUDIO_METER_BEAT_EN to build the beat detector; otherwise beat is tied to 0.
module audio_level_meter #(
    parameter int DC_SHIFT     = 10,
    parameter int ATTACK_SHIFT = 1,
    parameter int DECAY_SHIFT  = 6,
    parameter int GAIN_SHIFT   = 2,
    parameter int AVG_SHIFT    = 8,
    parameter int BEAT_MIN     = 64,
    parameter int HOLDOFF      = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic [11:0] level,
    output logic        level_valid,
    output logic [3:0]  bar,
    output logic        beat
);

    logic [11:0]        s_r;
    logic               v1;
    logic [15:0]        dc_r;
    logic [11:0]        dev_r;
    logic               v2;
    logic [11:0]        env;

    logic [11:0]        dc_code;
    logic [11:0]        dev_next;
    logic signed [16:0] dc_err;
    logic signed [16:0] dc_next;
    logic [11:0]        env_step;
    logic [11:0]        env_new;
    logic [15:0]        gain;
    logic [3:0]         bar_new;
    logic               unused_bits;

    assign unused_bits = ^{sample[3:0], dc_next[16]};

    // NOTE: clocked processes use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_r <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= sample_valid;
            if (sample_valid) begin
                s_r <= sample[15:4];
            end
        end
    end

    // DC tracker in 12.4 fixed point; deviation uses the tracker value before this update.
    assign dc_code  = dc_r[15:4];
    assign dev_next = (s_r >= dc_code) ? (s_r - dc_code) : (dc_code - s_r);
    assign dc_err   = $signed({1'b0, s_r, 4'b0000}) - $signed({1'b0, dc_r});
    assign dc_next  = $signed({1'b0, dc_r}) + (dc_err >>> DC_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_r  <= 16'h8000;
            dev_r <= '0;
            v2    <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                dev_r <= dev_next;
                dc_r  <= dc_next[15:0];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        env_step = '0;
        env_new  = env;
        if (dev_r > env) begin
            env_step = (dev_r - env) >> ATTACK_SHIFT;
            if (env_step == '0) begin
                env_step = 12'd1;
            end
            env_new = env + env_step;
        end else if (env != '0) begin
            env_step = env >> DECAY_SHIFT;
            if (env_step == '0) begin
                env_step = 12'd1;
            end
            env_new = env - env_step;
        end
    end

    assign gain    = 16'(env_new) << GAIN_SHIFT;
    assign bar_new = (gain > 16'd4095) ? 4'hF : gain[11:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env         <= '0;
            level       <= '0;
            bar         <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= v2;
            if (v2) begin
                env   <= env_new;
                level <= env_new;
                bar   <= bar_new;
            end
        end
    end

`ifdef AUDIO_METER_BEAT_EN
    logic [15:0]        avg_r;
    logic [15:0]        holdoff;
    logic [12:0]        avg_thresh;
    logic signed [16:0] avg_err;
    logic signed [16:0] avg_next;
    logic               beat_hit;
    logic               unused_avg;

    // A beat is the envelope jumping above 1.5x its long-term average.
    assign avg_thresh = {1'b0, avg_r[15:4]} + {2'b00, avg_r[15:5]};
    assign beat_hit   = ({1'b0, env_new} > avg_thresh) && (env_new >= 12'(BEAT_MIN)) &&
                        (holdoff == '0);
    assign avg_err    = $signed({1'b0, env_new, 4'b0000}) - $signed({1'b0, avg_r});
    assign avg_next   = $signed({1'b0, avg_r}) + (avg_err >>> AVG_SHIFT);
    assign unused_avg = avg_next[16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avg_r   <= '0;
            holdoff <= '0;
            beat    <= 1'b0;
        end else begin
            beat <= 1'b0;
            if (v2) begin
                avg_r <= avg_next[15:0];
                if (beat_hit) begin
                    beat    <= 1'b1;
                    holdoff <= 16'(HOLDOFF);
                end else if (holdoff != '0) begin
                    holdoff <= holdoff - 16'd1;
                end
            end
        end
    end
`else
    assign beat = 1'b0;
`endif

endmodule

// File: tb/tb_audio_level_meter.sv
// Self-checking bench for audio_level_meter: randomized stimulus against an arithmetic reference model.
module tb_audio_level_meter;

    localparam int DC_SHIFT     = 10;
    localparam int ATTACK_SHIFT = 1;
    localparam int DECAY_SHIFT  = 6;
    localparam int GAIN_SHIFT   = 2;
    localparam int AVG_SHIFT    = 8;
    localparam int BEAT_MIN     = 64;
    localparam int HOLDOFF      = 2000;

    typedef struct {
        logic [11:0] level;
        logic [3:0]  bar;
        logic        beat;
        int          cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic [11:0] level;
    logic        level_valid;
    logic [3:0]  bar;
    logic        beat;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   stray_beats = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t mon_r;

    int m_dc, m_env, m_avg, m_hold;

    audio_level_meter #(
        .DC_SHIFT(DC_SHIFT), .ATTACK_SHIFT(ATTACK_SHIFT), .DECAY_SHIFT(DECAY_SHIFT),
        .GAIN_SHIFT(GAIN_SHIFT), .AVG_SHIFT(AVG_SHIFT), .BEAT_MIN(BEAT_MIN), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .level(level), .level_valid(level_valid), .bar(bar), .beat(beat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && level_valid) begin
            mon_r.level = level;
            mon_r.bar   = bar;
            mon_r.beat  = beat;
            mon_r.cyc   = cyc;
            obs_q.push_back(mon_r);
        end
        if (beat === 1'b1 && level_valid !== 1'b1) stray_beats++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        m_dc   = 32768;
        m_env  = 0;
        m_avg  = 0;
        m_hold = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // One conversion through the behavioural rules; pushes the expected output for cycle T+3.
    task automatic model_step(input logic [15:0] smp);
        int   s, dev, step, g;
        rec_t e;
        s   = int'(smp[15:4]);
        dev = s - m_dc / 16;
        if (dev < 0) dev = -dev;
        m_dc = m_dc + floor_div(s * 16 - m_dc, 1 << DC_SHIFT);
        if (dev > m_env) begin
            step = (dev - m_env) / (1 << ATTACK_SHIFT);
            if (step < 1) step = 1;
            m_env = m_env + step;
        end else if (m_env > 0) begin
            step = m_env / (1 << DECAY_SHIFT);
            if (step < 1) step = 1;
            m_env = m_env - step;
        end
        g       = m_env * (1 << GAIN_SHIFT);
        e.level = 12'(m_env);
        e.bar   = (g > 4095) ? 4'd15 : 4'(g / 256);
        e.beat  = 1'b0;
`ifdef AUDIO_METER_BEAT_EN
        begin
            int thr;
            thr = m_avg / 16 + (m_avg / 16) / 2;
            if (m_env > thr && m_env >= BEAT_MIN && m_hold == 0) begin
                e.beat = 1'b1;
                m_hold = HOLDOFF;
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
            end
            m_avg = m_avg + floor_div(m_env * 16 - m_avg, 1 << AVG_SHIFT);
        end
`endif
        e.cyc = cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] smp);
        model_step(smp);
        sample_valid = 1'b1;
        sample       = smp;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample       = 16'($urandom);
    endtask

    task automatic apply_reset();
        sample_valid = 1'b0;
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        model_reset();
    endtask

    function automatic logic [15:0] code_sample(input int code);
        logic [11:0] c;
        c = 12'(code);
        return {c, 4'h0};
    endfunction

    task automatic test_reset();
        rec_t e, o;
        #2;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({level, bar, beat, level_valid} !== 18'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got level=%0d bar=%0d beat=%b valid=%b, want all 0",
                         level, bar, beat, level_valid);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (6) begin
            send(16'h8000);
            idle(3);
        end
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_idle: no level_valid, want one at cyc %0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.level !== 12'd0 || o.bar !== 4'd0 || o.beat !== 1'b0 || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL reset_idle: got level=%0d bar=%0d beat=%b cyc=%0d, want 0/0/0 cyc=%0d",
                             o.level, o.bar, o.beat, o.cyc, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d extra level_valid, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_step_attack();
        rec_t e, o;
        apply_reset();
        send(16'hFFF0);
        idle(5);
        send(16'h8000);
        idle(5);
        n_cmp++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL step_count: got %0d outputs, want 2", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.level !== 12'd1023 || o.bar !== 4'd15 || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL step_rise: got level=%0d bar=%0d cyc=%0d, want 1023/15 cyc=%0d",
                         o.level, o.bar, o.cyc, e.cyc);
            end
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.level !== 12'd1008 || o.bar !== e.bar || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL step_fall: got level=%0d bar=%0d cyc=%0d, want 1008/%0d cyc=%0d",
                         o.level, o.bar, o.cyc, e.bar, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_decay_floor();
        rec_t e, o;
        int   prev = 1008;
        bit   saw_one_to_zero = 0;
        bit   mono_ok = 1;
        for (int i = 0; i < 400; i++) send(16'h8000);
        idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL decay_model: no level_valid, want one at cyc %0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.level !== e.level || o.bar !== e.bar || o.beat !== e.beat || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL decay_model: got level=%0d bar=%0d cyc=%0d, want %0d/%0d cyc=%0d",
                             o.level, o.bar, o.cyc, e.level, e.bar, e.cyc);
                end
                if (int'(o.level) > prev) mono_ok = 0;
                if (prev == 1 && o.level === 12'd0) saw_one_to_zero = 1;
                prev = int'(o.level);
            end
        end
        n_cmp++;
        if (!mono_ok || !saw_one_to_zero || prev != 0) begin
            n_fail++;
            $display("FAIL decay_floor: got monotonic=%0d one_to_zero=%0d final=%0d, want 1/1/0",
                     mono_ok, saw_one_to_zero, prev);
        end
        obs_q.delete();
    endtask

    task automatic test_throughput();
        rec_t e, o;
        int   start;
        int   n;
        start = cyc;
        for (int i = 0; i < 32; i++) send(16'($urandom));
        idle(6);
        n_cmp++;
        if (obs_q.size() != 32) begin
            n_fail++;
            $display("FAIL throughput_count: got %0d level_valid, want 32", obs_q.size());
        end
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.level !== e.level || o.bar !== e.bar || o.beat !== e.beat || o.cyc !== start + 3 + n) begin
                n_fail++;
                $display("FAIL throughput[%0d]: got level=%0d bar=%0d cyc=%0d, want %0d/%0d cyc=%0d",
                         n, o.level, o.bar, o.cyc, e.level, e.bar, start + 3 + n);
            end
            n++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random();
        rec_t e, o;
        int   v;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(1) == 1) v = int'($urandom_range(4095));
            else v = 2048 + int'($urandom_range(200)) - 100;
            send(code_sample(v));
            idle(int'($urandom_range(2)));
        end
        idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL random: no level_valid, want one at cyc %0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.level !== e.level || o.bar !== e.bar || o.beat !== e.beat || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL random: got level=%0d bar=%0d beat=%b cyc=%0d, want %0d/%0d/%b cyc=%0d",
                             o.level, o.bar, o.beat, o.cyc, e.level, e.bar, e.beat, e.cyc);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL random: got %0d extra level_valid, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_beat_holdoff();
        rec_t e, o;
        int   idx = 0;
        int   beats_a = 0, beats_b = 0, beats_c = 0;
        int   want_beat;
`ifdef AUDIO_METER_BEAT_EN
        want_beat = 1;
`else
        want_beat = 0;
`endif
        apply_reset();
        stray_beats = 0;
        for (int i = 0; i < 4000; i++) send(code_sample(($urandom_range(1) == 1) ? 2056 : 2040));
        for (int i = 0; i < 32; i++)   send(code_sample(($urandom_range(1) == 1) ? 3548 : 548));
        for (int i = 0; i < 500; i++)  send(code_sample(($urandom_range(1) == 1) ? 2056 : 2040));
        for (int i = 0; i < 32; i++)   send(code_sample(($urandom_range(1) == 1) ? 3548 : 548));
        for (int i = 0; i < 2000; i++) send(code_sample(($urandom_range(1) == 1) ? 2056 : 2040));
        for (int i = 0; i < 32; i++)   send(code_sample(($urandom_range(1) == 1) ? 3548 : 548));
        for (int i = 0; i < 100; i++)  send(code_sample(($urandom_range(1) == 1) ? 2056 : 2040));
        idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_model[%0d]: no level_valid, want one at cyc %0d", idx, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.level !== e.level || o.bar !== e.bar || o.beat !== e.beat || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL beat_model[%0d]: got level=%0d beat=%b cyc=%0d, want %0d/%b cyc=%0d",
                             idx, o.level, o.beat, o.cyc, e.level, e.beat, e.cyc);
                end
                if (o.beat === 1'b1) begin
                    if (idx < 4532) beats_a++;
                    else if (idx < 6564) beats_b++;
                    else beats_c++;
                end
            end
            idx++;
        end
        n_cmp++;
        if (beats_a != want_beat || beats_b != 0 || beats_c != want_beat) begin
            n_fail++;
            $display("FAIL beat_holdoff: got beats %0d/%0d/%0d, want %0d/0/%0d",
                     beats_a, beats_b, beats_c, want_beat, want_beat);
        end
        n_cmp++;
        if (stray_beats != 0) begin
            n_fail++;
            $display("FAIL beat_align: got %0d beats outside level_valid, want 0", stray_beats);
        end
        obs_q.delete();
    endtask

    task automatic test_async_reset();
        rec_t e, o;
        for (int i = 0; i < 8; i++) send(code_sample(($urandom_range(1) == 1) ? 3800 : 300));
        sample_valid = 1'b1;
        sample       = 16'hFFF0;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({level, bar, beat, level_valid} !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset: got level=%0d bar=%0d beat=%b valid=%b, want all 0",
                     level, bar, beat, level_valid);
        end
        sample_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle(1);
        rst = 1'b1;
        idle(6);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL async_flush: got %0d level_valid after reset, want 0", obs_q.size());
            obs_q.delete();
        end
        send(16'hFFF0);
        idle(5);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL async_restart: got %0d level_valid, want 1", obs_q.size());
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.level !== 12'd1023 || o.bar !== 4'd15 || o.cyc !== e.cyc) begin
                n_fail++;
                $display("FAIL async_restart: got level=%0d bar=%0d cyc=%0d, want 1023/15 cyc=%0d",
                         o.level, o.bar, o.cyc, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_step_attack();
        test_decay_floor();
        test_throughput();
        test_random();
        test_beat_holdoff();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
